otter_main_memory: RTL
======================

Name: otter_main_memory

Overview:
- Line-granular main-memory responder behind the OTTER L1 cache.
- Serves full-cache-line read and write requests from the cache line adapter (the initiator) with a fixed, parameterised access latency, modelling slow off-chip memory.
- It is the far end of the adapter's line-transfer interface.
- Replaces a single-cycle BRAM so cache miss penalties are visible.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line (line = 256 bits, 32 bytes).
- DEPTH_LINES, 2048, number of lines stored (64 KiB); must be a power of 2.
- LATENCY, 10, cycles from request acceptance to MM_DONE; legal range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- MM_REQ  in  1  request strobe from the adapter; held until accepted.
- MM_WE  in  1  1 = line write, 0 = line read; sampled at acceptance.
- MM_ADDR  in  32  byte address; bits [4:0] ignored (line aligned).
- MM_WDATA  in  LINE_WORDS*32  write line; word 0 in bits [31:0]; sampled at acceptance.
- MM_READY  out  1  responder idle; a request is accepted on a cycle with MM_REQ && MM_READY.
- MM_DONE  out  1  one-cycle pulse: read data valid, or write committed.
- MM_RDATA  out  LINE_WORDS*32  read line; valid while MM_DONE=1; holds until the next read's MM_DONE.

Behaviour:
- Reset values: MM_READY=1, MM_DONE=0, MM_RDATA=0, FSM=IDLE, counter=0. Storage array is NOT reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - MM_READY=1.
  - On MM_REQ, capture MM_WE, line index and MM_WDATA.
  - Next state: WAIT if LATENCY>1, else DONE. Load counter with LATENCY-1.
- WAIT:
  - MM_READY=0.
  - Counter decrements each cycle; when it reaches 1, next state is DONE.
- Entering DONE (the access edge):
  - Read: MM_RDATA <= mem[idx].
  - Write: mem[idx] <= captured wdata; MM_RDATA unchanged.
- DONE:
  - MM_DONE=1, MM_READY=0 for exactly one cycle, then IDLE.
- Latency: with acceptance in cycle 0, MM_DONE is high in cycle LATENCY and MM_READY returns in cycle LATENCY+1. Back-to-back throughput is one line per LATENCY+1 cycles.
- Index: idx = MM_ADDR[4+log2(DEPTH_LINES):5]. Upper bits are ignored, so addresses wrap modulo DEPTH_LINES lines.
- MM_REQ while MM_READY=0: ignored, not queued. The initiator keeps MM_REQ high until the accept cycle.
- Changes to MM_WE, MM_ADDR or MM_WDATA after acceptance: no effect.
- Reset mid-operation (WAIT or DONE): the transaction is aborted, the FSM returns to IDLE, and no MM_DONE pulse is produced.
  - Reset in WAIT: a pending write is not committed.
  - Reset coincident with the access edge: reset wins; no commit.
- Read-after-write to the same line: the read returns the written data, since the write is committed before the DONE cycle.
- Out-of-parameter LATENCY (0 or >255): elaboration error via static assertion.

Optional Feature:
- Macro: OTTER_MAIN_MEM_INIT_EN.
- Defined: storage is initialised at time zero from the hex file "otter_memory.mem" (one 32-bit word per line of text, word address order) via $readmemh. The program image is therefore visible to the cache on its first miss.
- Undefined: no initial block; storage contents are undefined (X in simulation) until written. Used for synthesis targets with external loading.

Decomposition:
- Package otter_mem_pkg holds:
  - LINE_WORDS, LINE_BITS (256), OFFSET_BITS (5).
  - typedef line_t (logic [LINE_BITS-1:0]).
  - typedef enum mm_state_t {IDLE, WAIT, DONE}.
- The adapter and controller share the same package.
- No sub-module is required. The storage array may optionally be split out as otter_line_ram (1R/1W, line-wide, synchronous read) to allow BRAM inference; the FSM and counter remain in otter_main_memory.

Test Plan:
1. Reset then idle: assert RST 2 cycles -> MM_READY=1, MM_DONE=0, MM_RDATA=0 on the first cycle after RST drops.
2. Write then read, LATENCY=10:
   - Write 0x00000000_..._11111111 pattern (word k = 0x1111_1111*k) to MM_ADDR=0x0000_0040 -> MM_DONE exactly in cycle 10 after acceptance; MM_READY=1 in cycle 11.
   - Then read 0x0000_0044 (same line) -> MM_RDATA equals the written line, word 3 = 0x3333_3333.
3. Wrap-around, DEPTH_LINES=2048:
   - Write line at 0x0001_0020, then read 0x0000_0020 -> same data (index 1).
   - Read 0x0000_0000 -> different line.
4. Ignored request while busy: hold MM_REQ with a second address during WAIT -> only the first transaction completes, at cycle LATENCY. The second is accepted on the cycle MM_READY returns and completes LATENCY cycles later.
5. Reset mid-write: accept a write of 0xDEAD_BEEF words to line 5, assert RST in cycle 4 -> no MM_DONE pulse; a subsequent read of line 5 returns the prior contents.
6. LATENCY=1 back-to-back:
   - MM_REQ held high for 3 reads -> accepts in cycles 0, 2, 4.
   - MM_DONE in cycles 1, 3, 5.
   - MM_RDATA stable between pulses.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared definitions for the OTTER line-transfer path (main memory,
// cache line adapter and cache controller).
package otter_mem_pkg;

   localparam int unsigned LINE_WORDS  = 8;
   localparam int unsigned LINE_BITS   = LINE_WORDS * 32;
   localparam int unsigned OFFSET_BITS = 5;

   typedef logic [LINE_BITS-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } mm_state_t;

endpackage

// File: rtl/otter_main_memory.sv
// Line-granular main-memory responder with a fixed access latency.
// One request is in flight at a time; MM_DONE pulses LATENCY cycles after
// acceptance.
module otter_main_memory #(
  parameter int unsigned LINE_WORDS  = 8,
  parameter int unsigned DEPTH_LINES = 2048,
  parameter int unsigned LATENCY     = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     MM_REQ,
  input  logic                     MM_WE,
  input  logic [31:0]              MM_ADDR,
  input  logic [LINE_WORDS*32-1:0] MM_WDATA,
  output logic                     MM_READY,
  output logic                     MM_DONE,
  output logic [LINE_WORDS*32-1:0] MM_RDATA
);
  import otter_mem_pkg::*;

  localparam int unsigned LBITS    = LINE_WORDS * 32;
  localparam int unsigned IDX_BITS = $clog2(DEPTH_LINES);
  localparam logic [7:0]  LAT_M1   = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("otter_main_memory: LATENCY must be in 1..255");
  end
  if ((1 << IDX_BITS) != DEPTH_LINES) begin : g_bad_depth
    $error("otter_main_memory: DEPTH_LINES must be a power of 2");
  end

  mm_state_t             state, next_state;
  logic [7:0]            cnt, cnt_next;
  logic                  cap_we;
  logic [IDX_BITS-1:0]   cap_idx;
  logic [LBITS-1:0]      cap_wdata;
  logic                  acc_we;
  logic [IDX_BITS-1:0]   acc_idx;
  logic [LBITS-1:0]      acc_wdata;
  logic                  accept;
  logic                  access;
  logic [IDX_BITS-1:0]   req_idx;
  logic [LBITS-1:0]      rdata;
  logic [LBITS-1:0]      mem [DEPTH_LINES];
  logic                  unused_addr;

  assign req_idx     = MM_ADDR[OFFSET_BITS +: IDX_BITS];
  assign unused_addr = ^{MM_ADDR[31:OFFSET_BITS+IDX_BITS], MM_ADDR[OFFSET_BITS-1:0]};
  assign accept      = MM_REQ && (state == IDLE);
  assign access      = (next_state == DONE) && (state != DONE);

  // With LATENCY==1 the access edge is also the accept edge, so the
  // captured copies are not loaded yet and the live inputs are used.
  assign acc_we    = (state == IDLE) ? MM_WE    : cap_we;
  assign acc_idx   = (state == IDLE) ? req_idx  : cap_idx;
  assign acc_wdata = (state == IDLE) ? MM_WDATA : cap_wdata;

  assign MM_RDATA = rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    MM_READY   = 1'b0;
    MM_DONE    = 1'b0;
    case (state)
      IDLE: begin
        MM_READY = 1'b1;
        if (MM_REQ) begin
          next_state = (LATENCY > 1) ? WAIT : DONE;
          cnt_next   = LAT_M1;
        end
      end
      WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt == 8'd1) next_state = DONE;
      end
      DONE: begin
        MM_DONE    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      cap_we    <= MM_WE;
      cap_idx   <= req_idx;
      cap_wdata <= MM_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata <= '0;
    end else if (access && !acc_we) begin
      rdata <= mem[acc_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && access && acc_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
